// File: rtl/mem_access_stage.sv
// RV32 memory-access stage: byte-lane steering, load extension, misalignment
// detection and MEM/WB registering over a valid/ready data-memory port.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        memtoreg_in,
    input  logic        regwrite_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic [1:0]  aj_control_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rd2_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] adder1_in,
    input  logic [31:0] adder2_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        misaligned_out,
    output logic        wb_valid,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t      state_r, state_nxt_s;
    logic        memtoreg_r, regwrite_r;
    logic [1:0]  aj_r;
    logic [31:0] alu_r, adder1_r, adder2_r;
    logic [2:0]  funct3_r;
    logic [4:0]  rd_r;
    logic        is_mem_s, mis_s;
    logic [1:0]  size_s;

    // Access size code: 0 byte, 1 half, 2 word (undefined encodings act as word)
    function automatic logic [1:0] access_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: access_size = 2'd0;
            3'b001, 3'b101: access_size = 2'd1;
            default:        access_size = 2'd2;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    lane_be = 4'b0001 << off;
            2'd1:    lane_be = off[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd0:    lane_wdata = {4{d[7:0]}};
            2'd1:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b100:  load_extract = {24'h000000, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b101:  load_extract = {16'h0000, h};
            default: load_extract = rdata;
        endcase
    endfunction

    function automatic logic [31:0] wb_select(input logic [1:0] aj, input logic [31:0] alu,
                                              input logic [31:0] a1, input logic [31:0] a2);
        case (aj)
            2'b01:   wb_select = a1;
            2'b10:   wb_select = a2;
            default: wb_select = alu;
        endcase
    endfunction

    assign is_mem_s  = memread_in | memwrite_in;
    assign size_s    = access_size(funct3_in);
    assign mis_s     = ((size_s == 2'd1) && alu_result_in[0]) ||
                       ((size_s == 2'd2) && (alu_result_in[1:0] != 2'b00));
    assign stall_out = (state_r == ACCESS);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: enter ACCESS on an aligned memory op, leave on ready
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid && is_mem_s && !mis_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request, latched instruction and MEM/WB registers
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'h0000_0000;
            dmem_wdata     <= 32'h0000_0000;
            dmem_be        <= 4'b0000;
            misaligned_out <= 1'b0;
            wb_valid       <= 1'b0;
            wb_regwrite    <= 1'b0;
            wb_rd          <= 5'd0;
            wb_data        <= 32'h0000_0000;
            memtoreg_r     <= 1'b0;
            regwrite_r     <= 1'b0;
            aj_r           <= 2'b00;
            alu_r          <= 32'h0000_0000;
            adder1_r       <= 32'h0000_0000;
            adder2_r       <= 32'h0000_0000;
            funct3_r       <= 3'b000;
            rd_r           <= 5'd0;
        end else begin
            misaligned_out <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!in_valid) begin
                        wb_valid    <= 1'b0;
                        wb_regwrite <= 1'b0;
                    end else if (!is_mem_s) begin
                        wb_valid    <= 1'b1;
                        wb_regwrite <= regwrite_in;
                        wb_rd       <= rd_in;
                        wb_data     <= wb_select(aj_control_in, alu_result_in, adder1_in, adder2_in);
                    end else if (mis_s) begin
                        misaligned_out <= 1'b1;
                        wb_valid       <= 1'b1;
                        wb_regwrite    <= 1'b0;
                        wb_rd          <= rd_in;
                        wb_data        <= 32'h0000_0000;
                    end else begin
                        wb_valid    <= 1'b0;
                        wb_regwrite <= 1'b0;
                        dmem_req    <= 1'b1;
                        dmem_we     <= memwrite_in;
                        dmem_addr   <= {alu_result_in[31:2], 2'b00};
                        dmem_be     <= lane_be(size_s, alu_result_in[1:0]);
                        dmem_wdata  <= memwrite_in ? lane_wdata(size_s, rd2_in) : 32'h0000_0000;
                        memtoreg_r  <= memtoreg_in;
                        regwrite_r  <= regwrite_in;
                        aj_r        <= aj_control_in;
                        alu_r       <= alu_result_in;
                        adder1_r    <= adder1_in;
                        adder2_r    <= adder2_in;
                        funct3_r    <= funct3_in;
                        rd_r        <= rd_in;
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        dmem_req    <= 1'b0;
                        dmem_we     <= 1'b0;
                        dmem_addr   <= 32'h0000_0000;
                        dmem_wdata  <= 32'h0000_0000;
                        dmem_be     <= 4'b0000;
                        wb_valid    <= 1'b1;
                        wb_regwrite <= regwrite_r;
                        wb_rd       <= rd_r;
                        wb_data     <= memtoreg_r ? load_extract(funct3_r, alu_r[1:0], dmem_rdata)
                                                  : wb_select(aj_r, alu_r, adder1_r, adder2_r);
                    end else begin
                        wb_valid    <= 1'b0;
                        wb_regwrite <= 1'b0;
                    end
                end
                default: begin
                    dmem_req    <= 1'b0;
                    wb_valid    <= 1'b0;
                    wb_regwrite <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed vector table, reset-in-ACCESS
// sequence and randomized instructions scored against an arithmetic reference model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, memtoreg_in, regwrite_in, memread_in, memwrite_in;
    logic [1:0]  aj_control_in;
    logic [31:0] alu_result_in, rd2_in, adder1_in, adder2_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic        stall_out, dmem_req, dmem_we, dmem_ready, misaligned_out;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_chk = 0;
    int n_fail = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in),
        .aj_control_in(aj_control_in), .alu_result_in(alu_result_in),
        .rd2_in(rd2_in), .funct3_in(funct3_in), .rd_in(rd_in),
        .adder1_in(adder1_in), .adder2_in(adder2_in),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .misaligned_out(misaligned_out), .wb_valid(wb_valid),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr, mw, mt, rw;
        logic [1:0]  aj;
        logic [2:0]  f3;
        logic [31:0] alu, rd2, a1, a2, rdata;
        int          dly;
        logic [4:0]  rd;
        logic [31:0] e_wb;
        logic        e_rw, e_mis;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
    } vec_t;

    vec_t tab[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mr, input logic mw, input logic mt, input logic rw,
                                input logic [1:0] aj, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] rd2, input logic [31:0] a1, input logic [31:0] a2,
                                input logic [31:0] rdata, input int dly, input logic [4:0] rd,
                                input logic [31:0] e_wb, input logic e_rw, input logic e_mis,
                                input logic [3:0] e_be, input logic [31:0] e_wd);
        vec_t v;
        v.mr = mr; v.mw = mw; v.mt = mt; v.rw = rw; v.aj = aj; v.f3 = f3;
        v.alu = alu; v.rd2 = rd2; v.a1 = a1; v.a2 = a2; v.rdata = rdata; v.dly = dly;
        v.rd = rd; v.e_wb = e_wb; v.e_rw = e_rw; v.e_mis = e_mis; v.e_be = e_be; v.e_wd = e_wd;
        return v;
    endfunction

    // Reference model: plain arithmetic on access sizes in bytes
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int off = int'(addr % 4);
        logic [31:0] sh = rdata >> (8 * off);
        logic [31:0] b = sh % 256;
        logic [31:0] h = sh % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return rdata;
        endcase
    endfunction

    function automatic vec_t m_expect(input vec_t v);
        vec_t r = v;
        int sz = m_size(v.f3);
        int off = int'(v.alu % 4);
        logic [31:0] sel = (v.aj == 2'd1) ? v.a1 : (v.aj == 2'd2) ? v.a2 : v.alu;
        logic mem = v.mr | v.mw;
        r.e_mis = mem && ((off % sz) != 0);
        r.e_rw  = r.e_mis ? 1'b0 : v.rw;
        r.e_wb  = (mem && v.mt) ? m_load(v.f3, v.alu, v.rdata) : sel;
        r.e_be  = 4'(((1 << sz) - 1) << off);
        r.e_wd  = (sz == 1) ? (v.rd2 % 256) * 32'h0101_0101 :
                  (sz == 2) ? (v.rd2 % 65536) * 32'h0001_0001 : v.rd2;
        return r;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic [31:0] g;
        logic mem = v.mr | v.mw;
        in_valid = 1'b1; memread_in = v.mr; memwrite_in = v.mw; memtoreg_in = v.mt;
        regwrite_in = v.rw; aj_control_in = v.aj; funct3_in = v.f3; alu_result_in = v.alu;
        rd2_in = v.rd2; adder1_in = v.a1; adder2_in = v.a2; rd_in = v.rd;
        @(posedge clk); #1;
        if (mem && !v.e_mis) begin
            for (int c = 0; c <= v.dly; c++) begin
                g = $urandom;
                in_valid = g[0]; memread_in = g[1]; memwrite_in = g[2]; memtoreg_in = g[3];
                regwrite_in = g[4]; funct3_in = g[7:5]; rd_in = g[12:8]; aj_control_in = g[14:13];
                alu_result_in = $urandom; rd2_in = $urandom;
                chk({tag, " stall"}, 32'(stall_out), 32'd1);
                chk({tag, " req"}, 32'(dmem_req), 32'd1);
                chk({tag, " we"}, 32'(dmem_we), 32'(v.mw));
                chk({tag, " addr"}, dmem_addr, v.alu & 32'hFFFF_FFFC);
                chk({tag, " wbv_busy"}, 32'(wb_valid), 32'd0);
                if (v.mw) begin
                    chk({tag, " be"}, 32'(dmem_be), 32'(v.e_be));
                    chk({tag, " wdata"}, dmem_wdata, v.e_wd);
                end
                dmem_ready = (c == v.dly);
                dmem_rdata = (c == v.dly) ? v.rdata : $urandom;
                @(posedge clk); #1;
            end
            dmem_ready = 1'b0;
        end
        in_valid = 1'b0;
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, " wb_regwrite"}, 32'(wb_regwrite), 32'(v.e_rw));
        chk({tag, " stall_done"}, 32'(stall_out), 32'd0);
        chk({tag, " req_done"}, 32'(dmem_req), 32'd0);
        chk({tag, " misaligned"}, 32'(misaligned_out), 32'(v.e_mis));
        if (!v.e_mis) begin
            chk({tag, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
            chk({tag, " wb_data"}, wb_data, v.e_wb);
        end else begin
            @(posedge clk); #1;
            chk({tag, " mis_pulse"}, 32'(misaligned_out), 32'd0);
            chk({tag, " wb_valid_off"}, 32'(wb_valid), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        logic [31:0] g;
        rst = 1'b1; in_valid = 1'b0; memtoreg_in = 1'b0; regwrite_in = 1'b0;
        memread_in = 1'b0; memwrite_in = 1'b0; aj_control_in = 2'b00;
        alu_result_in = 32'h0; rd2_in = 32'h0; funct3_in = 3'b000; rd_in = 5'd0;
        adder1_in = 32'h0; adder2_in = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;

        //              mr    mw    mt    rw    aj     f3      alu           rd2           a1            a2            rdata       dly rd     e_wb          e_rw  e_mis e_be     e_wd
        tab[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 32'hA5A5A5A5, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd21, 32'hA5A5A5A5, 1'b1, 1'b0, 4'b0000, 32'h0);
        tab[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 3'b000, 32'h00000099, 32'h0,        32'h00000010, 32'h00000077, 32'h0,        0, 5'd1,  32'h00000010, 1'b1, 1'b0, 4'b0000, 32'h0);
        tab[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b000, 32'h00000099, 32'h0,        32'h00000010, 32'h00000020, 32'h0,        0, 5'd2,  32'h00000020, 1'b1, 1'b0, 4'b0000, 32'h0);
        tab[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b000, 32'h12345678, 32'h0,        32'h00000010, 32'h00000020, 32'h0,        0, 5'd3,  32'h12345678, 1'b0, 1'b0, 4'b0000, 32'h0);
        tab[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 32'h00000104, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 2, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 4'b1111, 32'h0);
        tab[5]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 32'h00000007, 32'h0,        32'h0,        32'h0,        32'h80FFFFFF, 0, 5'd6,  32'hFFFFFF80, 1'b1, 1'b0, 4'b1000, 32'h0);
        tab[6]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b100, 32'h00000007, 32'h0,        32'h0,        32'h0,        32'h80FFFFFF, 1, 5'd7,  32'h00000080, 1'b1, 1'b0, 4'b1000, 32'h0);
        tab[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b001, 32'h00000002, 32'h12345678, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h00000002, 1'b0, 1'b0, 4'b1100, 32'h56785678);
        tab[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 32'h00000001, 32'h000000AB, 32'h0,        32'h0,        32'h0,        1, 5'd0,  32'h00000001, 1'b0, 1'b0, 4'b0010, 32'hABABABAB);
        tab[9]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010, 32'h00000008, 32'hCAFEF00D, 32'h0,        32'h0,        32'h0,        0, 5'd0,  32'h00000008, 1'b0, 1'b0, 4'b1111, 32'hCAFEF00D);
        tab[10] = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b001, 32'h00000002, 32'h0,        32'h0,        32'h0,        32'h80011234, 0, 5'd10, 32'hFFFF8001, 1'b1, 1'b0, 4'b1100, 32'h0);
        tab[11] = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b101, 32'h00000002, 32'h0,        32'h0,        32'h0,        32'h80011234, 3, 5'd11, 32'h00008001, 1'b1, 1'b0, 4'b1100, 32'h0);
        tab[12] = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b010, 32'h00000006, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd12, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0);
        tab[13] = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b001, 32'h00000003, 32'h0,        32'h0,        32'h0,        32'h0,        0, 5'd13, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0);
        tab[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010, 32'h00000002, 32'h11111111, 32'h0,        32'h0,        32'h0,        0, 5'd14, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0);
        tab[15] = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 32'h00000004, 32'h0,        32'h0,        32'h0,        32'h0000007F, 0, 5'd15, 32'h0000007F, 1'b1, 1'b0, 4'b0001, 32'h0);
        tab[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b010, 32'h0000000C, 32'h11223344, 32'h0,        32'h0,        32'h0,        0, 5'd16, 32'h0000000C, 1'b0, 1'b0, 4'b1111, 32'h11223344);
        tab[17] = mk(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 3'b011, 32'h00000008, 32'h0,        32'h0,        32'h0,        32'h13572468, 0, 5'd17, 32'h13572468, 1'b1, 1'b0, 4'b1111, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst stall", 32'(stall_out), 32'd0);
        chk("rst req", 32'(dmem_req), 32'd0);
        chk("rst be", 32'(dmem_be), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst misaligned", 32'(misaligned_out), 32'd0);

        for (int i = 0; i < 18; i++) apply(tab[i], $sformatf("vec%0d", i));

        // Reset while a load waits in ACCESS
        in_valid = 1'b1; memread_in = 1'b1; memwrite_in = 1'b0; memtoreg_in = 1'b1;
        regwrite_in = 1'b1; funct3_in = 3'b010; alu_result_in = 32'h00000040; rd_in = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rstacc req_before", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstacc req", 32'(dmem_req), 32'd0);
        chk("rstacc stall", 32'(stall_out), 32'd0);
        chk("rstacc wb_valid", 32'(wb_valid), 32'd0);
        chk("rstacc wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("rstacc wb_rd", 32'(wb_rd), 32'd0);
        chk("rstacc wb_data", wb_data, 32'd0);

        for (int i = 0; i < 200; i++) begin
            g = $urandom;
            v.mr = (g[1:0] == 2'd1) || (g[1:0] == 2'd3);
            v.mw = (g[1:0] == 2'd2) || (g[1:0] == 2'd3);
            v.mt = v.mr & ~v.mw & g[2];
            v.rw = g[3];
            v.aj = g[5:4];
            v.f3 = g[8:6];
            v.rd = g[13:9];
            v.dly = int'(g[15:14]);
            v.alu = $urandom;
            v.rd2 = $urandom; v.a1 = $urandom; v.a2 = $urandom; v.rdata = $urandom;
            apply(m_expect(v), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
